dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  Sequences every load/store from the MEM stage onto the data SRAM, which has a
//  variable-latency addr_ok/data_ok handshake. Builds byte enables and aligned
//  store data, extracts and sign/zero-extends load data, and raises stall_req to
//  the pipeline stall controller while a transaction is outstanding.
//  Sits between the EX/MEM register and the data SRAM port.
// PARAMETERS
//  TIMEOUT_CYC  255  cycles in REQ+WAIT before the access is aborted with err_timeout
// PORTS
//  clk           in   1   clock
//  rst           in   1   reset, synchronous, active-high
//  flush         in   1   kill current/pending access result
//  req_valid     in   1   access request from MEM stage
//  req_we        in   1   1=store, 0=load
//  req_size      in   2   0=byte, 1=half, 2=word (3 treated as word)
//  req_sign      in   1   sign-extend load result
//  req_addr      in   32  byte address
//  req_wdata     in   32  store data, LSB-justified
//  req_ready     out  1   controller idle and can accept
//  resp_valid    out  1   one-cycle pulse: access complete
//  resp_rdata    out  32  formatted load data (0 for stores)
//  resp_err      out  1   valid with resp_valid: timeout or misalign
//  stall_req     out  1   hold upstream pipeline
//  sram_en       out  1   SRAM request
//  sram_wen      out  4   byte write enables (0000 = read)
//  sram_addr     out  32  word-aligned address {addr[31:2],2'b00}
//  sram_wdata    out  32  lane-replicated store data
//  sram_addr_ok  in   1   SRAM accepted request
//  sram_data_ok  in   1   SRAM read data / write done
//  sram_rdata    in   32  SRAM read data
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0 except req_ready=1; latched request cleared.
//  - FSM states IDLE, REQ, WAIT, DONE.
//  - IDLE: req_ready=1. req_valid && !flush -> latch request, go REQ.
//  - REQ: sram_en=1; sram_wen/addr/wdata stable until sram_addr_ok.
//    addr_ok&&data_ok -> DONE; addr_ok only -> WAIT.
//  - WAIT: sram_en=0; data_ok -> capture formatted rdata, go DONE.
//  - DONE: resp_valid=1 for exactly one cycle, then IDLE.
//  - Minimum latency: accept in cycle 0, REQ in cycle 1, resp_valid in cycle 2.
//  - stall_req = (IDLE && req_valid && !flush) | REQ | WAIT; low in DONE.
//  - Store lanes: byte wen=0001<<a[1:0], wdata={4{d[7:0]}}; half wen=0011<<{a[1],0},
//    wdata={2{d[15:0]}}; word wen=1111, wdata=d.
//  - Load extract: byte lane a[1:0], half lane a[1]; extend per req_sign; word as-is.
//  - Flush in REQ/WAIT: set drop flag; SRAM handshake still completes (REQ holds
//    until addr_ok, WAIT until data_ok); on completion go IDLE with no resp_valid.
//    Flush with addr_ok in the same cycle: go WAIT with drop set.
//  - Timeout: counter clears on entering REQ and counts in REQ/WAIT. At TIMEOUT_CYC
//    go DONE with resp_err=1 and resp_rdata=0. Any late data_ok is ignored.
//  - Reset mid-transaction: immediate IDLE; SRAM side is reset by the same rst.
// CONFIGURATION
//  MISALIGN_CHK_EN defined: half with a[0]=1, or word with a[1:0]!=0, is accepted but
//    skips the SRAM (no sram_en). Next cycle is DONE with resp_err=1, resp_rdata=0.
//    stall_req is high for the accept cycle only.
//  Undefined: low address bits are ignored per size (half uses a[1], word aligned
//    down). Misalign never flags.
// STRUCTURE
//  Shared package dmem_pkg: SIZE_B/SIZE_H/SIZE_W encodings, FSM state localparams.
//  Sub-module dmem_lane_fmt (combinational): store wen/wdata generation and
//  load extract/extend. FSM, timeout counter and latches stay in the top module.
// TESTING
//  - lw a=0x100, addr_ok+data_ok same cycle, rdata=0xDEADBEEF -> resp_valid cycle 2,
//    resp_rdata=0xDEADBEEF, stall_req high cycles 0-1.
//  - sb a=0x103 d=0x5A -> sram_wen=1000, sram_wdata=0x5A5A5A5A, sram_addr=0x100.
//  - lb a=0x101 sign=1, rdata=0x0000_8000 -> 0xFFFFFF80.
//    lhu a=0x102, rdata=0xBEEF_0000 -> 0x0000BEEF.
//  - addr_ok delayed 3 cycles, data_ok 2 more -> sram_en/addr held stable.
//    resp_valid 1 cycle after data_ok.
//  - flush during WAIT -> no resp_valid; next req_valid accepted after data_ok.
//  - data_ok never returns -> resp_err=1 after TIMEOUT_CYC cycles.
//    With MISALIGN_CHK_EN: lw a=0x102 -> resp_err=1 at cycle 1, no sram_en.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access controller.
//   SIZE_B/SIZE_H/SIZE_W : req_size encodings (3 is treated as word)
//   dmem_state_t         : controller FSM states
package dmem_pkg;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } dmem_state_t;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatting for the data SRAM port.
//   Store side: byte write enables and lane-replicated write data.
//   Load side : lane extraction plus sign/zero extension.
// Ports:
//   we       in   1   store (1) / load (0); loads produce wen=0000
//   size     in   2   access size (SIZE_B/SIZE_H/SIZE_W, 3 = word)
//   addr_lo  in   2   low byte-address bits selecting the lane
//   sign     in   1   sign-extend load data
//   st_data  in   32  store data, LSB-justified
//   ld_raw   in   32  raw SRAM read word
//   wen      out  4   byte write enables
//   st_lanes out  32  replicated store data
//   ld_data  out  32  extracted and extended load data
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        sign,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_raw,
    output logic [3:0]  wen,
    output logic [31:0] st_lanes,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = ld_raw[{addr_lo, 3'b000} +: 8];
    // Halfword lane follows a[1] only; a[0] is ignored here.
    assign half_sel = addr_lo[1] ? ld_raw[31:16] : ld_raw[15:0];

    always_comb begin
        wen      = '0;
        st_lanes = '0;
        ld_data  = '0;
        case (size)
            SIZE_B: begin
                wen      = 4'b0001 << addr_lo;
                st_lanes = {4{st_data[7:0]}};
                ld_data  = {{24{sign & byte_sel[7]}}, byte_sel};
            end
            SIZE_H: begin
                wen      = addr_lo[1] ? 4'b1100 : 4'b0011;
                st_lanes = {2{st_data[15:0]}};
                ld_data  = {{16{sign & half_sel[15]}}, half_sel};
            end
            default: begin
                wen      = 4'b1111;
                st_lanes = st_data;
                ld_data  = ld_raw;
            end
        endcase
        if (!we) begin
            wen = '0;
        end
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller between the EX/MEM register and the data SRAM.
// Sequences one load/store at a time over the addr_ok/data_ok handshake,
// formats lanes, aborts on timeout and stalls the pipeline while busy.
// Optional build macro: MISALIGN_CHK_EN -- misaligned half/word accesses are
// accepted but answered with resp_err without touching the SRAM.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    kill current/pending access result
//   req_valid/we/size/sign   MEM-stage request
//   req_addr, req_wdata      byte address, LSB-justified store data
//   req_ready                idle, can accept
//   resp_valid/rdata/err     one-cycle completion pulse, load data, error
//   stall_req                hold upstream pipeline
//   sram_en/wen/addr/wdata   SRAM request side
//   sram_addr_ok/data_ok     SRAM handshake
//   sram_rdata               SRAM read data
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        stall_req,
    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic        sram_addr_ok,
    input  logic        sram_data_ok,
    input  logic [31:0] sram_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    dmem_state_t state, state_nx;

    logic             we_q;
    logic             sign_q;
    logic [1:0]       size_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic             drop_q;
    logic             err_q;
    logic [31:0]      rdata_q;
    logic [CNT_W-1:0] cnt_q;

    logic [3:0]  fmt_wen;
    logic [31:0] fmt_wdata;
    logic [31:0] fmt_rdata;

    logic accept;
    logic misalign;
    logic busy;
    logic timeout;
    logic complete;
    logic kill;

    dmem_lane_fmt u_fmt (
        .we       (we_q),
        .size     (size_q),
        .addr_lo  (addr_q[1:0]),
        .sign     (sign_q),
        .st_data  (wdata_q),
        .ld_raw   (sram_rdata),
        .wen      (fmt_wen),
        .st_lanes (fmt_wdata),
        .ld_data  (fmt_rdata)
    );

    assign accept = (state == S_IDLE) && req_valid && !flush;

`ifdef MISALIGN_CHK_EN
    assign misalign = ((req_size == SIZE_H) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign busy     = (state == S_REQ) || (state == S_WAIT);
    assign timeout  = busy && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    assign complete = ((state == S_REQ)  && sram_addr_ok && sram_data_ok) ||
                      ((state == S_WAIT) && sram_data_ok);
    // A flush arriving in the completing cycle drops the result as well.
    assign kill     = drop_q || flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            drop_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                we_q    <= req_we;
                sign_q  <= req_sign;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                drop_q  <= 1'b0;
                err_q   <= misalign;
                rdata_q <= '0;
                cnt_q   <= '0;
            end else if (busy) begin
                cnt_q <= cnt_q + 1'b1;
                if (flush) begin
                    drop_q <= 1'b1;
                end
                // Completion wins over a timeout landing in the same cycle.
                if (complete) begin
                    rdata_q <= we_q ? '0 : fmt_rdata;
                    err_q   <= 1'b0;
                end else if (timeout) begin
                    rdata_q <= '0;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        stall_req  = 1'b0;
        sram_en    = 1'b0;
        sram_wen   = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                stall_req = accept;
                if (accept) begin
                    state_nx = misalign ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                stall_req  = 1'b1;
                sram_en    = 1'b1;
                sram_wen   = fmt_wen;
                sram_addr  = {addr_q[31:2], 2'b00};
                sram_wdata = fmt_wdata;
                // Timeout is checked before addr_ok-only so the counter can
                // never run past its terminal value while moving to WAIT.
                if (sram_addr_ok && sram_data_ok) begin
                    state_nx = kill ? S_IDLE : S_DONE;
                end else if (timeout) begin
                    state_nx = kill ? S_IDLE : S_DONE;
                end else if (sram_addr_ok) begin
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                stall_req = 1'b1;
                if (sram_data_ok || timeout) begin
                    state_nx = kill ? S_IDLE : S_DONE;
                end
            end
            S_DONE: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_err   = err_q;
                state_nx   = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: the driver issues requests and plays
// the SRAM, pushing expected responses; a monitor pops them on resp_valid.
module tb_dmem_access_ctrl;

    localparam int unsigned TO = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_sign;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        stall_req;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        sram_addr_ok;
    logic        sram_data_ok;
    logic [31:0] sram_rdata;

    dmem_access_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_sign     (req_sign),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .stall_req    (stall_req),
        .sram_en      (sram_en),
        .sram_wen     (sram_wen),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_addr_ok (sram_addr_ok),
        .sram_data_ok (sram_data_ok),
        .sram_rdata   (sram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned cyc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference model: plain arithmetic on the access rules.
    function automatic bit mdl_misalign(input logic [1:0] size, input logic [31:0] a);
`ifdef MISALIGN_CHK_EN
        if (size == 2'd1) return (a % 2) != 0;
        if (size >= 2'd2) return (a % 4) != 0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] mdl_load(input logic [1:0] size, input logic sign,
                                             input logic [31:0] a, input logic [31:0] raw);
        logic [31:0] v;
        int sh;
        if (size == 2'd0) begin
            sh = 8 * int'(a % 4);
            v  = (raw >> sh) & 32'hFF;
            if (sign && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (size == 2'd1) begin
            sh = ((a % 4) >= 2) ? 16 : 0;
            v  = (raw >> sh) & 32'hFFFF;
            if (sign && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end else begin
            v = raw;
        end
        return v;
    endfunction

    task automatic mdl_store(input logic we, input logic [1:0] size, input logic [31:0] a,
                             input logic [31:0] d, output logic [3:0] wen, output logic [31:0] wd);
        int n;
        if (size == 2'd0) begin
            n   = int'(a % 4);
            wen = 4'(1 << n);
            wd  = (d & 32'hFF) * 32'h0101_0101;
        end else if (size == 2'd1) begin
            n   = ((a % 4) >= 2) ? 2 : 0;
            wen = 4'(3 << n);
            wd  = (d & 32'hFFFF) * 32'h0001_0001;
        end else begin
            wen = 4'hF;
            wd  = d;
        end
        if (!we) wen = 4'h0;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (req_ready !== 1'b1 && n < int'(TO) + 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (req_ready !== 1'b1) chk(name, 32'(req_ready), 32'd1);
    endtask

    // fl: 0 none, 1 flush on first REQ cycle, 2 flush on first WAIT cycle.
    task automatic run_txn(input logic we, input logic [1:0] size, input logic sign,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] raw,
                           input int a_dly, input int d_dly, input int fl, input bit no_data);
        exp_t        e;
        bit          mis;
        int unsigned c0;
        logic [3:0]  ewen;
        logic [31:0] ewd;
        mis = mdl_misalign(size, addr);
        mdl_store(we, size, addr, wd, ewen, ewd);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_size = size; req_sign = sign;
        req_addr = addr; req_wdata = wd;
        c0 = cyc;
        #4;
        chk("accept_ready", 32'(req_ready), 32'd1);
        chk("accept_stall", 32'(stall_req), 32'd1);
        @(posedge clk); #1;
        // Scramble request inputs to prove the controller latched them.
        req_valid = 1'b0; req_we = ~we; req_size = 2'($urandom); req_sign = ~sign;
        req_addr = $urandom; req_wdata = $urandom;
        if (mis) begin
            e.rdata = '0; e.err = 1'b1; e.cyc = c0 + 1;
            exp_q.push_back(e);
            #4;
            chk("mis_no_en", 32'(sram_en), 32'd0);
            chk("mis_stall", 32'(stall_req), 32'd0);
        end else begin
            if (fl == 0) begin
                e.rdata = (we || no_data) ? 32'd0 : mdl_load(size, sign, addr, raw);
                e.err   = no_data;
                e.cyc   = no_data ? c0 + TO + 1 : c0 + 2 + int'(a_dly) + int'(d_dly);
                exp_q.push_back(e);
            end
            for (int k = 0; k <= a_dly; k++) begin
                sram_addr_ok = (k == a_dly);
                sram_data_ok = (k == a_dly) && (d_dly == 0) && !no_data;
                sram_rdata   = sram_data_ok ? raw : $urandom;
                flush        = (fl == 1) && (k == 0);
                #4;
                chk("req_en", 32'(sram_en), 32'd1);
                chk("req_stall", 32'(stall_req), 32'd1);
                chk("req_addr", sram_addr, addr & 32'hFFFF_FFFC);
                chk("req_wen", 32'(sram_wen), 32'(ewen));
                if (we) chk("req_wdata", sram_wdata, ewd);
                @(posedge clk); #1;
            end
            sram_addr_ok = 1'b0; sram_data_ok = 1'b0; flush = 1'b0;
            if (!no_data) begin
                for (int j = 1; j <= d_dly; j++) begin
                    sram_data_ok = (j == d_dly);
                    sram_rdata   = sram_data_ok ? raw : $urandom;
                    flush        = (fl == 2) && (j == 1);
                    #4;
                    chk("wait_en", 32'(sram_en), 32'd0);
                    chk("wait_stall", 32'(stall_req), 32'd1);
                    @(posedge clk); #1;
                end
                sram_data_ok = 1'b0; flush = 1'b0;
                if (fl != 0) chk("drop_ready", 32'(req_ready), 32'd1);
            end
        end
        wait_ready("ready_timeout");
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && resp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_err", 32'(resp_err), 32'(e.err));
                    chk("resp_cycle", cyc, e.cyc);
                    chk("resp_stall", 32'(stall_req), 32'd0);
                end
            end
        end
    end

    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        int          ad, dd, fl, r;
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = '0;
        req_sign = 1'b0; req_addr = '0; req_wdata = '0;
        sram_addr_ok = 1'b0; sram_data_ok = 1'b0; sram_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #4;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_resp", 32'(resp_valid), 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);
        chk("rst_en", 32'(sram_en), 32'd0);
        chk("rst_wen", 32'(sram_wen), 32'd0);

        run_txn(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 1'b0);  // lw
        run_txn(1'b1, 2'd0, 1'b0, 32'h103, 32'h5A, 32'h0, 0, 1, 0, 1'b0);         // sb
        run_txn(1'b0, 2'd0, 1'b1, 32'h101, 32'h0, 32'h0000_8000, 1, 0, 0, 1'b0);  // lb
        run_txn(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'hBEEF_0000, 0, 2, 0, 1'b0);  // lhu
        run_txn(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'h1234_5678, 3, 2, 0, 1'b0);  // slow SRAM
        run_txn(1'b1, 2'd1, 1'b0, 32'h206, 32'hCAFE, 32'h0, 1, 1, 0, 1'b0);       // sh
        run_txn(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h1111_2222, 0, 3, 2, 1'b0);  // flush in WAIT
        run_txn(1'b0, 2'd2, 1'b0, 32'h304, 32'h0, 32'h3333_4444, 0, 2, 1, 1'b0);  // flush with addr_ok
        run_txn(1'b0, 2'd0, 1'b1, 32'h30F, 32'h0, 32'h7F00_0000, 2, 0, 1, 1'b0);  // flush in REQ
        run_txn(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 32'h0, 0, 0, 0, 1'b1);          // timeout
        run_txn(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 32'hA5A5_5A5A, 0, 0, 0, 1'b0);  // misaligned lw
        run_txn(1'b0, 2'd3, 1'b1, 32'h500, 32'h0, 32'h8765_4321, 0, 1, 0, 1'b0);  // size 3

        for (int i = 0; i < 150; i++) begin
            sz = 2'($urandom_range(0, 3));
            a  = 32'h1000 + ($urandom & 32'hFFF);
            ad = $urandom_range(0, 3);
            dd = $urandom_range(0, 3);
            r  = $urandom_range(0, 9);
            fl = (r == 0) ? 1 : ((r == 1 && dd > 0) ? 2 : 0);
            run_txn(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom, ad, dd, fl, 1'b0);
        end

        repeat (4) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
